// File: rtl/byteswap_framer.sv
// -----------------------------------------------------------------------------
// byteswap_framer
//
// Frames an unframed AXI-Stream input into a packet of a programmed byte
// length. A single ctrl_start pulse latches ctrl_length; the block then passes
// exactly ceil(length / bytes_per_beat) input beats through a one-deep output
// register. It marks the final beat with m_axis_tlast and trims its
// m_axis_tkeep to the residual byte count. Input beats beyond the programmed
// length are never consumed.
//
// Ports
//   s_axis_aclk      clock for all logic
//   s_axis_areset_n  asynchronous active-low reset
//   ctrl_start       single-cycle pulse, accepted only while idle
//   ctrl_length      transfer length in bytes, sampled with ctrl_start
//   ctrl_busy        high from the accepted start through the done pulse
//   ctrl_done        one-cycle pulse once the last beat has been delivered
//   s_axis_*         unframed input stream (tvalid/tready/tdata)
//   m_axis_*         framed output stream (tvalid/tready/tdata/tkeep/tlast)
// -----------------------------------------------------------------------------
module byteswap_framer #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_LENGTH_WIDTH     = 32
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_areset_n,

  input  logic                            ctrl_start,
  input  logic [C_LENGTH_WIDTH-1:0]       ctrl_length,
  output logic                            ctrl_busy,
  output logic                            ctrl_done,

  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,

  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                            m_axis_tlast
);

  localparam int BPB = C_AXIS_TDATA_WIDTH / 8;        // bytes per beat
  localparam int OFF = $clog2(BPB);                   // byte-offset bits
  localparam int CW  = C_LENGTH_WIDTH - OFF + 1;      // beat counter width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state;
  logic [CW-1:0]   beats_left;
  logic [OFF-1:0]  rem_q;       // length mod bytes-per-beat, shapes last tkeep
  logic            busy_q;

  logic [CW-1:0]   start_beats;
  logic            s_fire;
  logic            m_fire;

  // Keep mask of the final beat: low 'r' bytes valid, or a full beat when the
  // length is an exact multiple of the beat size.
  function automatic logic [BPB-1:0] tail_keep(input logic [OFF-1:0] r);
    logic [BPB-1:0] k;
    k = '0;
    for (int i = 0; i < BPB; i++) begin
      k[i] = (r == '0) || (i < int'(r));
    end
    return k;
  endfunction

  // ceil(length / BPB): whole beats plus one if any residual bytes remain.
  // The extra counter bit keeps the maximum length from wrapping.
  assign start_beats = CW'(ctrl_length >> OFF) + CW'(|ctrl_length[OFF-1:0]);

  // Accept input only while running and the output register can take a beat
  // on this edge (empty, or being emptied by the downstream handshake).
  assign s_axis_tready = (state == RUN) && (!m_axis_tvalid || m_axis_tready);
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign m_fire        = m_axis_tvalid && m_axis_tready;

  // Busy covers the start cycle itself, so the start term is combinational;
  // it is gated by reset so every output reads 0 while reset is held.
  assign ctrl_busy = busy_q ||
                     (state == IDLE && ctrl_start && s_axis_areset_n);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees pre-edge values regardless of statement order.
  // The output data register is reset too: all outputs must read 0 in reset.
  always_ff @(posedge s_axis_aclk or negedge s_axis_areset_n) begin
    if (!s_axis_areset_n) begin
      state         <= IDLE;
      beats_left    <= '0;
      rem_q         <= '0;
      busy_q        <= 1'b0;
      ctrl_done     <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tlast  <= 1'b0;
    end else begin
      ctrl_done <= 1'b0;

      // A delivered beat empties the register unless RUN reloads it below.
      if (m_fire) begin
        m_axis_tvalid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (ctrl_start) begin
            rem_q      <= ctrl_length[OFF-1:0];
            beats_left <= start_beats;
            busy_q     <= 1'b1;
            if (start_beats == '0) begin
              state     <= DONE;
              ctrl_done <= 1'b1;
            end else begin
              state     <= RUN;
            end
          end
        end

        RUN: begin
          if (s_fire) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= s_axis_tdata;
            beats_left    <= beats_left - CW'(1);
            if (beats_left == CW'(1)) begin
              m_axis_tlast <= 1'b1;
              m_axis_tkeep <= tail_keep(rem_q);
              state        <= DRAIN;
            end else begin
              m_axis_tlast <= 1'b0;
              m_axis_tkeep <= '1;
            end
          end
        end

        DRAIN: begin
          if (m_fire) begin
            state     <= DONE;
            ctrl_done <= 1'b1;
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/byteswap_framer.md
BYTESWAP_FRAMER -- requirements
Module: byteswap_framer

Interface
REQ-001 Parameter C_AXIS_TDATA_WIDTH, default 512: stream data width in bits; SHALL be a power of two, 32..1024.
REQ-002 Parameter C_LENGTH_WIDTH, default 32: width of the byte-length operand.
REQ-003 s_axis_aclk  in  1  single clock for all logic; one clock domain.
REQ-004 s_axis_areset_n  in  1  reset, asynchronous assert, active-low.
REQ-005 ctrl_start  in  1  single-cycle pulse; begins one transfer.
REQ-006 ctrl_length  in  C_LENGTH_WIDTH  transfer length in bytes; sampled when ctrl_start is accepted.
REQ-007 ctrl_busy  out  1  high from accepted start until done pulse inclusive.
REQ-008 ctrl_done  out  1  single-cycle pulse when the transfer is complete.
REQ-009 s_axis_tvalid / s_axis_tready / s_axis_tdata  in/out/in  1/1/C_AXIS_TDATA_WIDTH  unframed input beats; no tkeep or tlast.
REQ-010 m_axis_tvalid / m_axis_tready  out/in  1/1  framed output handshake.
REQ-011 m_axis_tdata / m_axis_tkeep / m_axis_tlast  out  C_AXIS_TDATA_WIDTH / C_AXIS_TDATA_WIDTH/8 / 1  framed output beat, consumed by the byteswap swapper.

Function
REQ-012 The block SHALL have states IDLE, RUN, DRAIN and DONE.
REQ-013 IDLE: on ctrl_start=1, latch ctrl_length, compute beats = ceil(length/(C_AXIS_TDATA_WIDTH/8)), and go to RUN; if length=0, go to DONE instead.
REQ-014 ctrl_start SHALL be ignored in every state other than IDLE.
REQ-015 RUN: s_axis_tready = (~m_axis_tvalid | m_axis_tready); s_axis_tready SHALL be 0 in IDLE, DRAIN and DONE.
REQ-016 Every input beat accepted in RUN SHALL be registered into the output stage on the same edge with 1-cycle latency, and the remaining-beat counter SHALL decrement.
REQ-017 When the final beat is accepted (counter = 1), m_axis_tlast SHALL be 1 for that beat, and the block SHALL go to DRAIN.
REQ-018 m_axis_tkeep SHALL be all ones on non-last beats.
REQ-019 On the last beat, m_axis_tkeep SHALL have its low (length mod bytes-per-beat) bits set, or all ones if the remainder is 0.
REQ-020 DRAIN: when m_axis_tvalid & m_axis_tready, go to DONE.
REQ-021 DONE: assert ctrl_done for exactly one cycle, then go to IDLE.
REQ-022 The output register SHALL hold m_axis_tdata, m_axis_tkeep and m_axis_tlast stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-023 m_axis_tvalid SHALL clear on the cycle after acceptance unless a new beat loads on that same edge; full throughput is 1 beat/cycle.
REQ-024 Input beats beyond the programmed length SHALL NOT be consumed.
REQ-025 The beat counter SHALL be C_LENGTH_WIDTH-log2(C_AXIS_TDATA_WIDTH/8)+1 bits wide, so that maximum length does not wrap.

Reset
REQ-026 While s_axis_areset_n=0, the state SHALL be IDLE and the counter cleared.
REQ-027 While s_axis_areset_n=0, all outputs SHALL be 0: s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, ctrl_busy and ctrl_done.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer: the in-flight output beat is discarded and no ctrl_done is issued.
REQ-029 After reset deassertion, the block SHALL accept ctrl_start on the first clock edge.

Verification
REQ-030 Length 128, width 512, m_axis_tready=1 -> 2 output beats, both with tkeep=64'hFFFF_FFFF_FFFF_FFFF; tlast only on beat 2; ctrl_done 1 cycle after beat 2 is accepted.
REQ-031 Length 100 -> 2 beats; beat 2 has tkeep=64'h0000_000F_FFFF_FFFF and tlast=1; a 3rd offered input beat is left unaccepted (s_axis_tready=0).
REQ-032 Length 0 -> ctrl_done on the cycle after start; m_axis_tvalid never asserted; ctrl_busy high for exactly 2 cycles.
REQ-033 Length 256 with m_axis_tready held low 5 cycles mid-stream -> m_axis_tdata, tkeep and tlast are stable; s_axis_tready=0 during the stall; 4 beats delivered in order with no loss or duplication.
REQ-034 ctrl_start pulsed during RUN with a different length -> ignored; the original length completes.
REQ-035 s_axis_areset_n pulled low after beat 1 of 4 -> all outputs 0 immediately with no done pulse; a new length-64 transfer then yields 1 beat with tlast=1.
